// File: rtl/iob_fp_round.sv
// iob_fp_round: registered round-to-nearest-even stage for the FP back end.
// Takes a normalised mantissa {M, G, R, S} and its biased exponent. Returns
// the rounded exponent and the stored fraction, with the hidden bit dropped.
// When rounding carries out of M, the exponent is renormalised by +1.
// Optional feature macro: IOB_FP_ROUND_OVF_EN adds ovf_o and saturates the
// result to infinity. Without it, the exponent wraps modulo 2^EXP_W.
module iob_fp_round #(
  parameter int DATA_W = 24,
  parameter int EXP_W  = 8
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              cke_i,
  input  logic              en_i,
  input  logic [EXP_W-1:0]  exponent_i,
  input  logic [DATA_W+2:0] mantissa_i,
  output logic              done_o,
  output logic [EXP_W-1:0]  exponent_rnd_o,
  output logic [DATA_W-2:0] mantissa_rnd_o
`ifdef IOB_FP_ROUND_OVF_EN
  ,
  output logic              ovf_o
`endif
);

  // Round-to-nearest-even decision. A tie (G set, R and S clear) rounds up
  // only when the kept LSB is odd.
  function automatic logic round_up(input logic l, input logic g,
                                    input logic r, input logic s);
    return g & (l | r | s);
  endfunction

  logic [DATA_W-1:0] m;
  logic              rnd;
  logic [DATA_W:0]   mr;
  logic              carry;
  logic [DATA_W-2:0] frac_nxt;
  logic [EXP_W-1:0]  exp_nxt;

  assign m     = mantissa_i[DATA_W+2:3];
  assign rnd   = round_up(m[0], mantissa_i[2], mantissa_i[1], mantissa_i[0]);
  assign mr    = {1'b0, m} + {{DATA_W{1'b0}}, rnd};
  assign carry = mr[DATA_W];

`ifdef IOB_FP_ROUND_OVF_EN
  logic [EXP_W:0] exp_sum;
  logic           ovf_nxt;

  // The exponent overflows when it reaches the all-ones code. That happens
  // either through the carry increment or because the input is already
  // all ones.
  function automatic logic exp_overflow(input logic [EXP_W:0] e);
    return e >= {1'b0, {EXP_W{1'b1}}};
  endfunction

  assign exp_sum = {1'b0, exponent_i} + {{EXP_W{1'b0}}, carry};
  assign ovf_nxt = exp_overflow(exp_sum);

  // On overflow, saturate to infinity. Otherwise, take the renormalised
  // exponent and the rounded fraction.
  always_comb begin
    exp_nxt  = exp_sum[EXP_W-1:0];
    frac_nxt = carry ? mr[DATA_W-1:1] : mr[DATA_W-2:0];
    if (ovf_nxt) begin
      exp_nxt  = {EXP_W{1'b1}};
      frac_nxt = '0;
    end
  end
`else
  // On carry-out, the exponent increments and wraps modulo 2^EXP_W. In that
  // case the shifted fraction is all zeros.
  always_comb begin
    exp_nxt  = exponent_i + {{(EXP_W-1){1'b0}}, carry};
    frac_nxt = carry ? mr[DATA_W-1:1] : mr[DATA_W-2:0];
  end
`endif

  // ---- stage p1: result register ----
  logic              vld_p1;
  logic [EXP_W-1:0]  exp_p1;
  logic [DATA_W-2:0] frac_p1;
`ifdef IOB_FP_ROUND_OVF_EN
  logic              ovf_p1;
`endif

  // Valid follows en_i on every enabled cycle. Results load only for
  // accepted operands. Reset clears everything, so an in-flight result is
  // dropped.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      vld_p1  <= 1'b0;
      exp_p1  <= '0;
      frac_p1 <= '0;
`ifdef IOB_FP_ROUND_OVF_EN
      ovf_p1  <= 1'b0;
`endif
    end else if (cke_i) begin
      vld_p1 <= en_i;
      if (en_i) begin
        exp_p1  <= exp_nxt;
        frac_p1 <= frac_nxt;
`ifdef IOB_FP_ROUND_OVF_EN
        ovf_p1  <= ovf_nxt;
`endif
      end
    end
  end

  assign done_o         = vld_p1;
  assign exponent_rnd_o = exp_p1;
  assign mantissa_rnd_o = frac_p1;
`ifdef IOB_FP_ROUND_OVF_EN
  assign ovf_o          = ovf_p1;
`endif

endmodule

// File: tb/tb_iob_fp_round.sv
// Testbench for iob_fp_round (DATA_W=24, EXP_W=8).
// Covers both builds, with and without IOB_FP_ROUND_OVF_EN.
module tb_iob_fp_round;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        cke;
  logic        en;
  logic [7:0]  exp_in;
  logic [26:0] mant_in;
  logic        done;
  logic [7:0]  exp_rnd;
  logic [22:0] frac_rnd;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  iob_fp_round #(.DATA_W(24), .EXP_W(8)) dut (
    .clk_i          (clk),
    .arst_n_i       (arst_n),
    .cke_i          (cke),
    .en_i           (en),
    .exponent_i     (exp_in),
    .mantissa_i     (mant_in),
    .done_o         (done),
    .exponent_rnd_o (exp_rnd),
    .mantissa_rnd_o (frac_rnd)
`ifdef IOB_FP_ROUND_OVF_EN
    ,
    .ovf_o          (ovf)
`endif
  );

`ifndef IOB_FP_ROUND_OVF_EN
  assign ovf = 1'b0;
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference model, computed as plain arithmetic on the value M + {G,R,S}/8.
  // Returns {ovf, exponent[7:0], fraction[22:0]}.
  function automatic logic [31:0] model(input logic [7:0] e, input logic [26:0] mant);
    int unsigned mv, rem, mr, ex, frac;
    bit o;
    mv  = int'(mant) >> 3;
    rem = int'(mant) & 7;
    // Round up above half; on an exact half, round up only if M is odd.
    mr  = mv + (((rem > 4) || (rem == 4 && (mv % 2) == 1)) ? 1 : 0);
    ex  = int'(e);
    o   = 1'b0;
    if (mr == (1 << 24)) begin
      ex   = ex + 1;
      frac = 0;
    end else begin
      frac = mr % (1 << 23);
    end
`ifdef IOB_FP_ROUND_OVF_EN
    if (ex >= 255) begin
      ex   = 255;
      frac = 0;
      o    = 1'b1;
    end
`else
    ex = ex % 256;
`endif
    return {o, ex[7:0], frac[22:0]};
  endfunction

  task automatic check_result(input string tag, input logic [31:0] expv);
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_exp"},  64'(exp_rnd), 64'(expv[30:23]));
    check({tag, "_frac"}, 64'(frac_rnd), 64'(expv[22:0]));
    check({tag, "_ovf"},  64'(ovf), 64'(expv[31]));
  endtask

  // Apply one operand and check it on the following falling edge.
  task automatic directed(input string tag, input logic [7:0] e, input logic [26:0] mt,
                          input logic [31:0] expv);
    @(negedge clk);
    cke = 1'b1; en = 1'b1; exp_in = e; mant_in = mt;
    @(negedge clk);
    en = 1'b0;
    check_result(tag, expv);
  endtask

  logic [31:0] pend_exp;
  bit          pend;
  logic [31:0] held;
  logic [26:0] mt;

  initial begin
    arst_n = 1'b0; cke = 1'b0; en = 1'b0; exp_in = '0; mant_in = '0;
    #3;
    check("rst_done", 64'(done), 64'd0);
    check("rst_exp",  64'(exp_rnd), 64'd0);
    check("rst_frac", 64'(frac_rnd), 64'd0);
    check("rst_ovf",  64'(ovf), 64'd0);
    @(negedge clk);
    arst_n = 1'b1;

    // Directed vectors: tie-even, round up, carry, truncate, exponent wrap/overflow.
    directed("tie_even", 8'd10, 27'h7FFFFF4, {1'b0, 8'd10, 23'h7FFFFE});
    directed("grs_up",   8'd10, 27'h7FFFFE6, {1'b0, 8'd10, 23'h7FFFFD});
    directed("carry",    8'd10, 27'h7FFFFFC, {1'b0, 8'd11, 23'h0});
    directed("trunc",    8'd10, 27'h7FFFFFB, {1'b0, 8'd10, 23'h7FFFFF});
`ifdef IOB_FP_ROUND_OVF_EN
    directed("exp_top",  8'd255, 27'h7FFFFFC, {1'b1, 8'd255, 23'h0});
    directed("exp_254c", 8'd254, 27'h7FFFFFC, {1'b1, 8'd255, 23'h0});
`else
    directed("exp_wrap", 8'd255, 27'h7FFFFFC, {1'b0, 8'd0, 23'h0});
`endif
    directed("zero",     8'd0, 27'h0, {1'b0, 8'd0, 23'h0});
    directed("denorm_up", 8'd0, 27'h000000C, {1'b0, 8'd0, 23'h2});

    // Streaming sweep: all exponents, low nibble 0..15, top bits all ones then zeros.
    pend = 1'b0;
    for (int top = 0; top < 2; top++) begin
      for (int e = 0; e < 256; e++) begin
        for (int nib = 0; nib < 16; nib++) begin
          @(negedge clk);
          if (pend) check_result("sweep", pend_exp);
          mt = (top == 0) ? {23'h7FFFFF, 4'(nib)} : {23'h0, 4'(nib)};
          cke = 1'b1; en = 1'b1; exp_in = 8'(e); mant_in = mt;
          pend_exp = model(8'(e), mt);
          pend = 1'b1;
        end
      end
    end

    // Random operands, streamed back to back.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (pend) check_result("rand", pend_exp);
      exp_in  = 8'($urandom_range(255));
      mant_in = 27'($urandom);
      if ((i % 8) == 0) mant_in[26:4] = '1;
      pend_exp = model(exp_in, mant_in);
    end
    @(negedge clk);
    en = 1'b0;
    check_result("rand_last", pend_exp);

    // An idle enabled cycle clears done and leaves the data unchanged.
    @(negedge clk);
    check("idle_done", 64'(done), 64'd0);
    check("idle_exp",  64'(exp_rnd), 64'(pend_exp[30:23]));
    check("idle_frac", 64'(frac_rnd), 64'(pend_exp[22:0]));

    // Asynchronous reset while a result is held clears the outputs at once.
    directed("pre_rst", 8'd77, 27'h1234567, model(8'd77, 27'h1234567));
    en = 1'b1; exp_in = 8'd99; mant_in = 27'h7FFFFFF;
    #2 arst_n = 1'b0;
    #1;
    check("arst_done", 64'(done), 64'd0);
    check("arst_exp",  64'(exp_rnd), 64'd0);
    check("arst_frac", 64'(frac_rnd), 64'd0);
    check("arst_ovf",  64'(ovf), 64'd0);
    @(negedge clk);
    check("arst_hold_exp", 64'(exp_rnd), 64'd0);
    en = 1'b0;
    arst_n = 1'b1;

    // With cke low, every register holds, even when a new operand is offered.
    held = model(8'd200, 27'h2AAAAAD);
    directed("pre_cke", 8'd200, 27'h2AAAAAD, held);
    cke = 1'b0; en = 1'b1; exp_in = 8'd5; mant_in = 27'h0F0F0F0;
    @(negedge clk);
    @(negedge clk);
    check_result("cke_hold", held);
    en = 1'b0;
    @(negedge clk);
    check("cke_hold_done", 64'(done), 64'd1);
    cke = 1'b1;
    @(negedge clk);
    check("cke_resume_done", 64'(done), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
